// File: rtl/key_event_unit.sv
// Multi-channel push-button front end: per key a 2-flop synchroniser, tick-sampled
// debounce and an IDLE/HELD/LONG event FSM emitting one-cycle event pulses.

module key_event_lane #(
    parameter int STABLE_SAMPLES = 4,
    parameter int LONG_TICKS     = 50,
    parameter int REPEAT_TICKS   = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic clear,
    input  logic raw,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic repeat_pulse
);
    localparam int SW = $clog2(STABLE_SAMPLES + 1);
    localparam int HW = $clog2(LONG_TICKS + 1);
    localparam int RW = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;
    localparam logic [SW-1:0] STAB_TERM = SW'(STABLE_SAMPLES - 1);
    localparam logic [HW-1:0] HOLD_TERM = HW'(LONG_TICKS - 1);
    localparam logic [RW-1:0] RPT_TERM  = (REPEAT_TICKS > 0) ? RW'(REPEAT_TICKS - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_HELD, S_LONG} state_t;

    state_t        state;
    logic          s1, s;
    logic [SW-1:0] stab;
    logic [HW-1:0] hold;
    logic [RW-1:0] rcnt;
    logic          flip;

    // Synchroniser deliberately ignores clear so a held key is re-detected afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s  <= 1'b0;
        end else begin
            s1 <= raw;
            s  <= s1;
        end
    end

    assign flip = (s != level) && (stab == STAB_TERM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            level         <= 1'b0;
            stab          <= '0;
            hold          <= '0;
            rcnt          <= '0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            if (clear) begin
                state <= S_IDLE;
                level <= 1'b0;
                stab  <= '0;
                hold  <= '0;
                rcnt  <= '0;
            end else if (tick) begin
                if (s == level)
                    stab <= '0;
                else if (flip) begin
                    stab  <= '0;
                    level <= ~level;
                end else
                    stab <= stab + 1'b1;

                // A level flip outranks any hold/repeat terminal count on the same tick.
                if (flip && !level) begin
                    press <= 1'b1;
                    state <= S_HELD;
                    hold  <= '0;
                end else if (flip) begin
                    release_pulse <= 1'b1;
                    state         <= S_IDLE;
                    hold          <= '0;
                    rcnt          <= '0;
                end else begin
                    case (state)
                        S_HELD: begin
                            if (hold == HOLD_TERM) begin
                                long_press <= 1'b1;
                                state      <= S_LONG;
                                hold       <= '0;
                                rcnt       <= '0;
                            end else
                                hold <= hold + 1'b1;
                        end
                        S_LONG: begin
                            if (REPEAT_TICKS > 0) begin
                                if (rcnt == RPT_TERM) begin
                                    repeat_pulse <= 1'b1;
                                    rcnt         <= '0;
                                end else
                                    rcnt <= rcnt + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

module key_event_unit #(
    parameter int N_KEYS         = 7,
    parameter int STABLE_SAMPLES = 4,
    parameter int LONG_TICKS     = 50,
    parameter int REPEAT_TICKS   = 10,
    parameter bit ACTIVE_LOW_IN  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              clear,
    input  logic [N_KEYS-1:0] btn_in,
    output logic [N_KEYS-1:0] level,
    output logic [N_KEYS-1:0] press,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_press,
    output logic [N_KEYS-1:0] repeat_pulse,
    output logic              any_held
);
    logic [N_KEYS-1:0] raw;

    assign raw      = btn_in ^ {N_KEYS{ACTIVE_LOW_IN}};
    assign any_held = |level;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_lane
        key_event_lane #(
            .STABLE_SAMPLES(STABLE_SAMPLES),
            .LONG_TICKS    (LONG_TICKS),
            .REPEAT_TICKS  (REPEAT_TICKS)
        ) u_lane (
            .clk          (clk),
            .rst_n        (rst_n),
            .tick         (tick),
            .clear        (clear),
            .raw          (raw[g]),
            .level        (level[g]),
            .press        (press[g]),
            .release_pulse(release_pulse[g]),
            .long_press   (long_press[g]),
            .repeat_pulse (repeat_pulse[g])
        );
    end
endmodule

// File: tb/tb_key_event_unit.sv
// Directed bench for key_event_unit: default parameters, tick every 4 clk.

module tb_key_event_unit;
    localparam int N = 7;

    logic         clk = 1'b0, rst_n = 1'b0, tick = 1'b0, clear = 1'b0;
    logic [N-1:0] btn_in = '0;
    logic [N-1:0] level, press, release_pulse, long_press, repeat_pulse;
    logic         any_held;

    int total = 0, bad = 0, tick_no = 0;
    int press_cnt[N], rel_cnt[N], long_cnt[N], rpt_cnt[N];
    int press_tk[N], rel_tk[N], long_tk[N], rpt_tk[N], rpt_prev[N];
    int pb[N], rb[N], lb[N], qb[N];
    bit both_seen = 1'b0;

    always #5 clk = ~clk;

    key_event_unit dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .clear(clear), .btn_in(btn_in),
        .level(level), .press(press), .release_pulse(release_pulse),
        .long_press(long_press), .repeat_pulse(repeat_pulse), .any_held(any_held)
    );

    // Event recorder: counts every high cycle of each pulse and remembers the tick that caused it.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (press[i])         begin press_cnt[i]++; press_tk[i] = tick_no; end
            if (release_pulse[i]) begin rel_cnt[i]++;   rel_tk[i]   = tick_no; end
            if (long_press[i])    begin long_cnt[i]++;  long_tk[i]  = tick_no; end
            if (repeat_pulse[i])  begin rpt_cnt[i]++; rpt_prev[i] = rpt_tk[i]; rpt_tk[i] = tick_no; end
        end
        if ((press & release_pulse) != '0) both_seen = 1'b1;
    end

    task step_tick();
        repeat (2) @(negedge clk);
        @(negedge clk); tick = 1'b1; tick_no++;
        @(negedge clk); tick = 1'b0;
        #1;
    endtask

    task run_to(input int t);
        while (tick_no < t) step_tick();
    endtask

    task snap();
        for (int i = 0; i < N; i++) begin
            pb[i] = press_cnt[i]; rb[i] = rel_cnt[i]; lb[i] = long_cnt[i]; qb[i] = rpt_cnt[i];
        end
    endtask

    task test_reset();
        repeat (2) @(negedge clk);
        #1;
        total++; if (level !== '0)         begin bad++; $display("FAIL reset_level got=%h exp=0", level); end
        total++; if (press !== '0)         begin bad++; $display("FAIL reset_press got=%h exp=0", press); end
        total++; if (release_pulse !== '0) begin bad++; $display("FAIL reset_release got=%h exp=0", release_pulse); end
        total++; if (long_press !== '0)    begin bad++; $display("FAIL reset_long got=%h exp=0", long_press); end
        total++; if (repeat_pulse !== '0)  begin bad++; $display("FAIL reset_repeat got=%h exp=0", repeat_pulse); end
        total++; if (any_held !== 1'b0)    begin bad++; $display("FAIL reset_any_held got=%b exp=0", any_held); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task test_single_press();
        int t0;
        int others;
        snap(); t0 = tick_no;
        btn_in[0] = 1'b1;
        repeat (3) step_tick();
        total++; if (level[0] !== 1'b0) begin bad++; $display("FAIL press0_early got=%b exp=0", level[0]); end
        step_tick();
        total++; if (press_tk[0] != t0 + 4) begin bad++; $display("FAIL press0_tick got=%0d exp=%0d", press_tk[0], t0 + 4); end
        total++; if (press_cnt[0] - pb[0] != 1) begin bad++; $display("FAIL press0_width got=%0d exp=1", press_cnt[0] - pb[0]); end
        total++; if (level !== 7'b0000001) begin bad++; $display("FAIL press0_level got=%b exp=0000001", level); end
        total++; if (any_held !== 1'b1) begin bad++; $display("FAIL press0_any_held got=%b exp=1", any_held); end
        others = 0;
        for (int i = 1; i < N; i++) others += press_cnt[i] - pb[i];
        total++; if (others != 0) begin bad++; $display("FAIL press0_others got=%0d exp=0", others); end
        btn_in[0] = 1'b0;
        repeat (4) step_tick();
        total++; if (rel_cnt[0] - rb[0] != 1) begin bad++; $display("FAIL release0_count got=%0d exp=1", rel_cnt[0] - rb[0]); end
        total++; if (any_held !== 1'b0) begin bad++; $display("FAIL release0_any_held got=%b exp=0", any_held); end
    endtask

    task test_bounce();
        int t0;
        snap(); t0 = tick_no;
        for (int k = 0; k < 10; k++) begin
            btn_in[2] = (k % 2 == 0);
            step_tick();
        end
        total++; if (press_cnt[2] - pb[2] != 0) begin bad++; $display("FAIL bounce_early got=%0d exp=0", press_cnt[2] - pb[2]); end
        btn_in[2] = 1'b1;
        repeat (8) step_tick();
        total++; if (press_cnt[2] - pb[2] != 1) begin bad++; $display("FAIL bounce_count got=%0d exp=1", press_cnt[2] - pb[2]); end
        total++; if (press_tk[2] != t0 + 14) begin bad++; $display("FAIL bounce_tick got=%0d exp=%0d", press_tk[2], t0 + 14); end
        btn_in[2] = 1'b0;
        repeat (4) step_tick();
    endtask

    task test_long_repeat();
        int p;
        snap(); p = tick_no + 4;
        btn_in[1] = 1'b1;
        run_to(p);
        total++; if (press_tk[1] != p) begin bad++; $display("FAIL long1_press_tick got=%0d exp=%0d", press_tk[1], p); end
        run_to(p + 49);
        total++; if (long_cnt[1] - lb[1] != 0) begin bad++; $display("FAIL long1_early got=%0d exp=0", long_cnt[1] - lb[1]); end
        step_tick();
        total++; if (long_tk[1] != p + 50) begin bad++; $display("FAIL long1_tick got=%0d exp=%0d", long_tk[1], p + 50); end
        total++; if (long_cnt[1] - lb[1] != 1) begin bad++; $display("FAIL long1_count got=%0d exp=1", long_cnt[1] - lb[1]); end
        run_to(p + 70);
        total++; if (rpt_prev[1] != p + 60) begin bad++; $display("FAIL repeat1_first got=%0d exp=%0d", rpt_prev[1], p + 60); end
        total++; if (rpt_tk[1] != p + 70) begin bad++; $display("FAIL repeat1_second got=%0d exp=%0d", rpt_tk[1], p + 70); end
        run_to(p + 80);
        btn_in[1] = 1'b0;
        run_to(p + 86);
        total++; if (rel_tk[1] != p + 84) begin bad++; $display("FAIL release1_tick got=%0d exp=%0d", rel_tk[1], p + 84); end
        total++; if (rel_cnt[1] - rb[1] != 1) begin bad++; $display("FAIL release1_count got=%0d exp=1", rel_cnt[1] - rb[1]); end
        total++; if (rpt_cnt[1] - qb[1] != 3) begin bad++; $display("FAIL repeat1_count got=%0d exp=3", rpt_cnt[1] - qb[1]); end
    endtask

    task test_release_at_long();
        int p;
        snap(); p = tick_no + 4;
        btn_in[3] = 1'b1;
        run_to(p + 46);
        btn_in[3] = 1'b0;
        run_to(p + 55);
        total++; if (rel_tk[3] != p + 50) begin bad++; $display("FAIL release3_tick got=%0d exp=%0d", rel_tk[3], p + 50); end
        total++; if (rel_cnt[3] - rb[3] != 1) begin bad++; $display("FAIL release3_count got=%0d exp=1", rel_cnt[3] - rb[3]); end
        total++; if (long_cnt[3] - lb[3] != 0) begin bad++; $display("FAIL long3_suppressed got=%0d exp=0", long_cnt[3] - lb[3]); end
        total++; if (level[3] !== 1'b0) begin bad++; $display("FAIL level3_after got=%b exp=0", level[3]); end
    endtask

    task test_clear();
        int p, c;
        snap(); p = tick_no + 4;
        btn_in[4] = 1'b1;
        run_to(p + 55);
        total++; if (long_cnt[4] - lb[4] != 1) begin bad++; $display("FAIL clear4_in_long got=%0d exp=1", long_cnt[4] - lb[4]); end
        c = tick_no;
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        #1;
        total++; if (level[4] !== 1'b0) begin bad++; $display("FAIL clear4_level got=%b exp=0", level[4]); end
        total++; if (any_held !== 1'b0) begin bad++; $display("FAIL clear4_any_held got=%b exp=0", any_held); end
        repeat (4) step_tick();
        total++; if (rel_cnt[4] - rb[4] != 0) begin bad++; $display("FAIL clear4_no_release got=%0d exp=0", rel_cnt[4] - rb[4]); end
        total++; if (press_tk[4] != c + 4) begin bad++; $display("FAIL clear4_repress_tick got=%0d exp=%0d", press_tk[4], c + 4); end
        total++; if (press_cnt[4] - pb[4] != 2) begin bad++; $display("FAIL clear4_press_count got=%0d exp=2", press_cnt[4] - pb[4]); end
        btn_in[4] = 1'b0;
        repeat (5) step_tick();
    endtask

    task test_reset_mid_hold();
        int r, missed;
        btn_in = '1;
        repeat (6) step_tick();
        total++; if (level !== 7'h7F) begin bad++; $display("FAIL all_held_level got=%h exp=7f", level); end
        @(negedge clk); rst_n = 1'b0;
        #1;
        total++; if (level !== '0) begin bad++; $display("FAIL midreset_level got=%h exp=0", level); end
        total++; if (any_held !== 1'b0) begin bad++; $display("FAIL midreset_any_held got=%b exp=0", any_held); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        snap(); r = tick_no;
        step_tick();
        total++; if (rel_cnt[5] - rb[5] != 0) begin bad++; $display("FAIL midreset_no_release got=%0d exp=0", rel_cnt[5] - rb[5]); end
        repeat (3) step_tick();
        missed = 0;
        for (int i = 0; i < N; i++)
            if (press_cnt[i] - pb[i] != 1 || press_tk[i] != r + 4) missed++;
        total++; if (missed != 0) begin bad++; $display("FAIL midreset_presses got=%0d bad_channels exp=0", missed); end
        total++; if (level !== 7'h7F) begin bad++; $display("FAIL midreset_relevel got=%h exp=7f", level); end
        btn_in = '0;
        repeat (5) step_tick();
        total++; if (any_held !== 1'b0) begin bad++; $display("FAIL final_any_held got=%b exp=0", any_held); end
    endtask

    task test_no_overlap();
        total++; if (both_seen !== 1'b0) begin bad++; $display("FAIL press_release_overlap got=%b exp=0", both_seen); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_long_repeat();
        test_release_at_long();
        test_clear();
        test_reset_mid_hold();
        test_no_overlap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
